vga_fade_mixer: RTL and testbench

Downstream output stage between the parallax scroller's RGB222/sync outputs and the `uo_out` pins. It scales each colour channel by a frame-synchronous brightness level (0..4) driven by a fade state machine. Sync is delayed so it stays aligned with colour. The result is packed into the standard TinyVGA pin order.

---
 rtl/vga_fade_mixer.sv | 169 ++++++++++++++++
 tb/tb_vga_fade_mixer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fade_mixer.sv
// Output stage: scales RGB222 by a frame-synchronous fade level (0..4), delays syncs to match,
// and packs into TinyVGA pin order. Define FADE_DITHER_EN for 2x2 ordered dither on the colour.
module vga_fade_mixer #(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pix_r,
    input  logic [1:0] pix_g,
    input  logic [1:0] pix_b,
    input  logic       pix_hsync,
    input  logic       pix_vsync,
    input  logic       pix_visible,
    input  logic       pix_x0,
    input  logic       pix_y0,
    input  logic       fade_target,
    output logic [7:0] out_uo,
    output logic [2:0] level,
    output logic       fade_busy,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        BLACK    = 2'd0,
        FADE_IN  = 2'd1,
        SHOW     = 2'd2,
        FADE_OUT = 2'd3
    } state_e;

    localparam logic [3:0] LAST_STEP = 4'(FRAMES_PER_STEP - 1);

    state_e     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic [3:0] step_q, step_d;
    logic       vs_prev_q;
    logic       tick;

    // Falling edge of vsync lands in vertical blanking, so level never changes mid-frame.
    assign tick = vs_prev_q & ~pix_vsync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BLACK;
            level_q   <= 3'd0;
            step_q    <= 4'd0;
            vs_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            step_q    <= step_d;
            vs_prev_q <= pix_vsync;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = step_q;
        case (state_q)
            BLACK: begin
                if (tick && fade_target) begin
                    state_d = FADE_IN;
                    step_d  = 4'd0;
                end
            end
            FADE_IN: begin
                if (tick) begin
                    if (!fade_target) begin
                        state_d = FADE_OUT;
                        step_d  = 4'd0;
                    end else if (step_q == LAST_STEP) begin
                        level_d = level_q + 3'd1;
                        step_d  = 4'd0;
                        if (level_q == 3'd3) state_d = SHOW;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            SHOW: begin
                if (tick && !fade_target) begin
                    state_d = FADE_OUT;
                    step_d  = 4'd0;
                end
            end
            FADE_OUT: begin
                if (tick) begin
                    if (fade_target) begin
                        state_d = FADE_IN;
                        step_d  = 4'd0;
                    end else if (step_q == LAST_STEP) begin
                        level_d = level_q - 3'd1;
                        step_d  = 4'd0;
                        if (level_q == 3'd1) state_d = BLACK;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = BLACK;
                level_d = 3'd0;
                step_d  = 4'd0;
            end
        endcase
    end

    // p = c * level is at most 12; the top two bits are floor(p/4).
    logic [3:0] p_r, p_g, p_b;
    logic [1:0] c_r, c_g, c_b;

    assign p_r = {2'b00, pix_r} * {1'b0, level_q};
    assign p_g = {2'b00, pix_g} * {1'b0, level_q};
    assign p_b = {2'b00, pix_b} * {1'b0, level_q};

`ifdef FADE_DITHER_EN
    logic [1:0] thresh;

    always_comb begin
        case ({pix_x0, pix_y0})
            2'b00:   thresh = 2'd0;
            2'b10:   thresh = 2'd2;
            2'b01:   thresh = 2'd3;
            default: thresh = 2'd1;
        endcase
    end

    // Remainder is always 0 at level 0 and 4, so the dither has no effect there.
    function automatic logic [1:0] shade(input logic [3:0] p, input logic [1:0] t);
        if ((p[1:0] > t) && (p[3:2] != 2'd3)) return p[3:2] + 2'd1;
        return p[3:2];
    endfunction

    assign c_r = shade(p_r, thresh);
    assign c_g = shade(p_g, thresh);
    assign c_b = shade(p_b, thresh);
`else
    assign c_r = p_r[3:2];
    assign c_g = p_g[3:2];
    assign c_b = p_b[3:2];

    wire _unused = &{1'b0, pix_x0, pix_y0, p_r[1:0], p_g[1:0], p_b[1:0]};
`endif

    logic [1:0] r_q, g_q, b_q;
    logic       hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q  <= 2'd0;
            g_q  <= 2'd0;
            b_q  <= 2'd0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            r_q  <= pix_visible ? c_r : 2'd0;
            g_q  <= pix_visible ? c_g : 2'd0;
            b_q  <= pix_visible ? c_b : 2'd0;
            hs_q <= pix_hsync;
            vs_q <= pix_vsync;
        end
    end

    assign out_uo    = {hs_q, b_q[0], g_q[0], r_q[0], vs_q, b_q[1], g_q[1], r_q[1]};
    assign level     = level_q;
    assign fade_busy = (state_q == FADE_IN) || (state_q == FADE_OUT);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_vga_fade_mixer.sv
// Directed bench for vga_fade_mixer with a scoreboard of expected out_uo and a reference fade model.
module tb_vga_fade_mixer;

    localparam int FPS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pix_r = 2'd0, pix_g = 2'd0, pix_b = 2'd0;
    logic       pix_hsync = 1'b1, pix_vsync = 1'b1, pix_visible = 1'b0;
    logic       pix_x0 = 1'b0, pix_y0 = 1'b0, fade_target = 1'b0;
    logic [7:0] out_uo;
    logic [2:0] level;
    logic       fade_busy;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    vga_fade_mixer #(.FRAMES_PER_STEP(FPS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_hsync   (pix_hsync),
        .pix_vsync   (pix_vsync),
        .pix_visible (pix_visible),
        .pix_x0      (pix_x0),
        .pix_y0      (pix_y0),
        .fade_target (fade_target),
        .out_uo      (out_uo),
        .level       (level),
        .fade_busy   (fade_busy),
        .fsm_state   (fsm_state)
    );

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference fade model: 0=BLACK 1=FADE_IN 2=SHOW 3=FADE_OUT
    int   m_state = 0, m_level = 0, m_step = 0;
    logic m_vprev = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic int scale(input int c, input int lvl, input logic x0, input logic y0);
        int s, t;
        s = (c * lvl) / 4;
        t = 0;
`ifdef FADE_DITHER_EN
        if (!x0 && !y0) t = 0;
        else if (x0 && !y0) t = 2;
        else if (!x0 && y0) t = 3;
        else t = 1;
        if (((c * lvl) % 4) > t && s < 3) s = s + 1;
`endif
        return s;
    endfunction

    function automatic logic [7:0] model_out(input int lvl);
        logic [1:0] r, g, b;
        r = pix_visible ? 2'(scale(int'(pix_r), lvl, pix_x0, pix_y0)) : 2'd0;
        g = pix_visible ? 2'(scale(int'(pix_g), lvl, pix_x0, pix_y0)) : 2'd0;
        b = pix_visible ? 2'(scale(int'(pix_b), lvl, pix_x0, pix_y0)) : 2'd0;
        return {pix_hsync, b[0], g[0], r[0], pix_vsync, b[1], g[1], r[1]};
    endfunction

    // One clock: push expectation, advance model, then compare after the edge.
    task automatic cycle();
        logic [7:0] got_exp;
        if (!rst_n) begin
            exp_q.push_back(8'h88);
            m_state = 0; m_level = 0; m_step = 0; m_vprev = 1'b1;
        end else begin
            exp_q.push_back(model_out(m_level));
            if (m_vprev && !pix_vsync) begin
                case (m_state)
                    0: if (fade_target) begin m_state = 1; m_step = 0; end
                    1: if (!fade_target) begin m_state = 3; m_step = 0; end
                       else if (m_step == FPS - 1) begin
                           m_level++; m_step = 0;
                           if (m_level == 4) m_state = 2;
                       end else m_step++;
                    2: if (!fade_target) begin m_state = 3; m_step = 0; end
                    default: if (fade_target) begin m_state = 1; m_step = 0; end
                       else if (m_step == FPS - 1) begin
                           m_level--; m_step = 0;
                           if (m_level == 0) m_state = 0;
                       end else m_step++;
                endcase
            end
            m_vprev = pix_vsync;
        end
        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        chk("out_uo", out_uo, got_exp);
        chk("level", {5'd0, level}, 8'(m_level));
        chk("fade_busy", {7'd0, fade_busy}, {7'd0, (m_state == 1 || m_state == 3)});
        chk("fsm_state", {6'd0, fsm_state}, 8'(m_state));
    endtask

    task automatic rand_pix();
        pix_r       = 2'($urandom_range(0, 3));
        pix_g       = 2'($urandom_range(0, 3));
        pix_b       = 2'($urandom_range(0, 3));
        pix_visible = 1'($urandom_range(0, 1));
        pix_hsync   = 1'($urandom_range(0, 1));
        pix_x0      = 1'($urandom_range(0, 1));
        pix_y0      = 1'($urandom_range(0, 1));
    endtask

    task automatic vsync_edge();
        for (int i = 0; i < 3; i++) begin
            pix_vsync = (i == 0) ? 1'b0 : 1'b1;
            rand_pix();
            cycle();
        end
    endtask

    task automatic set_pix(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                           input logic vis, input logic x0, input logic y0);
        pix_r = r; pix_g = g; pix_b = b; pix_visible = vis;
        pix_x0 = x0; pix_y0 = y0; pix_hsync = 1'b1; pix_vsync = 1'b1;
    endtask

    initial begin
        logic [1:0] dith_exp [4];
        logic [1:0] xy;
        dith_exp[0] = 2'd2; dith_exp[1] = 2'd1; dith_exp[2] = 2'd1; dith_exp[3] = 2'd2;

        // Reset with arbitrary inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_pix();
            pix_vsync   = 1'($urandom_range(0, 1));
            fade_target = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("reset_out", out_uo, 8'h88);
        chk("reset_level", {5'd0, level}, 8'd0);
        chk("reset_busy", {7'd0, fade_busy}, 8'd0);

        rst_n = 1'b1;
        fade_target = 1'b0;
        set_pix(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        pix_hsync = 1'b0;
        cycle();
        chk("hsync_lo", {7'd0, out_uo[7]}, 8'd0);

        // Fade-in over 20 vsync edges
        fade_target = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            vsync_edge();
            if (e == 5)  chk("fadein_l1", {5'd0, level}, 8'd1);
            if (e == 9)  chk("fadein_l2", {5'd0, level}, 8'd2);
            if (e == 13) chk("fadein_l3", {5'd0, level}, 8'd3);
            if (e == 16) chk("busy_before_show", {7'd0, fade_busy}, 8'd1);
            if (e == 17) begin
                chk("fadein_l4", {5'd0, level}, 8'd4);
                chk("busy_show", {7'd0, fade_busy}, 8'd0);
            end
        end

        // Back to BLACK, then fade up to level 2
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) vsync_edge();
        chk("l2_reached", {5'd0, level}, 8'd2);

        // Scaling at level 2
        set_pix(2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle();
`ifndef FADE_DITHER_EN
        chk("scale_l2", out_uo, 8'hB8);
`endif
        set_pix(2'd3, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("blank_l2", out_uo, 8'h88);

        // Channel 3 at level 2 across the dither positions
        for (int k = 0; k < 4; k++) begin
            xy = 2'(k);
            set_pix(2'd3, 2'd3, 2'd3, 1'b1, xy[0], xy[1]);
            cycle();
`ifdef FADE_DITHER_EN
            chk("dither_l2_r", {6'd0, out_uo[0], out_uo[4]}, {6'd0, dith_exp[k]});
`else
            chk("plain_l2_r", {6'd0, out_uo[0], out_uo[4]}, 8'd1);
`endif
        end

        // Reversal from FADE_IN at level 2
        fade_target = 1'b0;
        vsync_edge();
        chk("rev_state", {6'd0, fsm_state}, 8'd3);
        chk("rev_level", {5'd0, level}, 8'd2);
        for (int e = 0; e < 3; e++) vsync_edge();
        chk("rev_hold", {5'd0, level}, 8'd2);
        vsync_edge();
        chk("rev_l1", {5'd0, level}, 8'd1);

        // Climb to level 3, reverse, then reset mid-fade
        fade_target = 1'b1;
        for (int e = 0; e < 9; e++) vsync_edge();
        chk("climb_l3", {5'd0, level}, 8'd3);
        set_pix(2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        cycle();
`ifdef FADE_DITHER_EN
        chk("dither_l3_r", {6'd0, out_uo[0], out_uo[4]}, 8'd3);
`else
        chk("plain_l3_r", {6'd0, out_uo[0], out_uo[4]}, 8'd2);
`endif
        fade_target = 1'b0;
        vsync_edge();
        chk("fo_state", {6'd0, fsm_state}, 8'd3);
        chk("fo_level", {5'd0, level}, 8'd3);
        rst_n = 1'b0;
        fade_target = 1'b1;
        cycle();
        chk("midrst_level", {5'd0, level}, 8'd0);
        chk("midrst_state", {6'd0, fsm_state}, 8'd0);
        rst_n = 1'b1;
        vsync_edge();
        chk("reenter_state", {6'd0, fsm_state}, 8'd1);
        chk("reenter_busy", {7'd0, fade_busy}, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
